mc_controller: RTL and testbench
================================

# mc_controller

Multi-cycle control unit for the MIPS datapath. It replaces the single-cycle decoder with a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It inserts wait states on a memory-ready handshake and counts retired instructions. It sits between the instruction register (opcode/funct) and the datapath enables (PC, IR, register file, ALU, memory).

## Interface
- ALU_CTL_W, 2, width of alu_ctl; must be ≥2; bits above [1:0] always 0
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in EXE
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  IR load enable
- iord  out  1  memory address: 0=PC, 1=ALU result
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- alu_ctl  out  ALU_CTL_W  00 addu, 01 subu, 10 or, 11 lui
- alu_src  out  1  ALU B: 0=rt, 1=extended imm
- ext_op  out  1  1=sign-extend, 0=zero-extend
- npc_sel  out  2  00 PC+4, 01 branch target, 10 jump target
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  WB source: 1=memory data
- reg_write  out  1  register file write enable
- link  out  1  write PC+4 to $31 (jal only)
- illegal  out  1  one-cycle pulse on unsupported instruction
- retired  out  CNT_W  retired-instruction count

## Operation
- Supported: addu(0/21h), subu(0/23h), ori(0Dh), lui(0Fh), lw(23h), sw(2Bh), beq(04h), j(02h).
- States: IF → DCD → EXE → {MEM, WB, IF}; MEM → {WB, IF}; WB → IF.
- IF: mem_read=1, iord=0, npc_sel=00. Hold in IF while mem_ready=0. On mem_ready=1: ir_write=1, pc_write=1, go to DCD.
- DCD: one cycle, no enables. Legal opcode → EXE. Otherwise illegal=1 and go to IF.
- EXE, R-type/ori/lui: alu_ctl per op, alu_src=1 for ori/lui, then → WB.
- EXE, lw/sw: alu_ctl=00, alu_src=1, ext_op=1, then → MEM.
- EXE, beq: alu_ctl=01, npc_sel=01, ext_op=1, pc_write=zero, then → IF.
- EXE, j: npc_sel=10, pc_write=1, then → IF.
- MEM: iord=1, ALU inputs held as in EXE. lw asserts mem_read and sw asserts mem_write. Hold while mem_ready=0. On mem_ready=1, lw → WB and sw → IF.
- WB: reg_write=1. reg_dst=1 for addu/subu. mem_to_reg=1 for lw. Then → IF.
- retired increments by 1 on the final cycle of every legal instruction (the WB cycle, EXE of beq/j, the completing MEM cycle of sw). It wraps modulo 2^CNT_W. It is not incremented for illegal instructions.
- Outputs not listed for a state are 0.

## Timing
- Outputs are Moore, decoded from state and latched instruction fields. Exceptions: pc_write/ir_write in IF and pc_write in EXE also depend combinationally on mem_ready/zero.
- Cycles with zero wait states: addu/subu/ori/lui 4, lw 5, sw 4, beq 3, j 3. Each mem_ready=0 cycle in IF or MEM adds one cycle.
- opcode/funct must be stable from DCD through the end of the instruction (IR is written only in IF).
- Reset, asynchronous at any state including mid-MEM: state=IF, retired=0. While rst=1, all outputs are 0, including mem_read, pc_write and ir_write. The first fetch starts the cycle after rst deasserts.
- mem_ready is ignored outside IF and MEM.

## Configuration
- MC_JAL_EN defined: jal (03h) is legal. In EXE: npc_sel=10, pc_write=1, reg_write=1, link=1, retired increments, then → IF (3 cycles).
- MC_JAL_EN undefined: jal is illegal (illegal pulse in DCD), and link is tied to 0.

## Test plan
- Reset during an lw in MEM with mem_ready=0 → next cycle state IF, all outputs 0, retired=0. After release, mem_read=1, iord=0.
- addu, mem_ready always 1 → ir_write/pc_write in cycle 1, reg_write=1 with reg_dst=1 in cycle 4, retired 0→1.
- lw with mem_ready low for 3 cycles in MEM → iord=1 and mem_read held for 4 MEM cycles, then WB with mem_to_reg=1. Total 8 cycles.
- beq with zero=0, then beq with zero=1 → pc_write=0, then pc_write=1 with npc_sel=01 in EXE. 3 cycles each, retired +2.
- Opcode 3Fh → illegal=1 for one cycle in DCD, back to IF, retired unchanged.
- jal with MC_JAL_EN defined → link=1, reg_write=1, npc_sel=10 in EXE. Without the macro → illegal pulse and link=0.

Source files
------------

// File: rtl/mc_controller.sv
// ============================================================================
// Module   : mc_controller
// Purpose  : Multi-cycle MIPS control unit. A Moore FSM walks each instruction
//            through IF -> DCD -> EXE -> {MEM, WB} -> IF. It adds wait states
//            on the mem_ready handshake and counts retired instructions.
// Options  : MC_JAL_EN - when defined, jal (opcode 03h) is a legal
//            instruction that links to $31. When undefined, jal is illegal
//            and link stays 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_controller #(
  parameter int ALU_CTL_W = 2,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic                 alu_src,
  output logic                 ext_op,
  output logic [1:0]           npc_sel,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 link,
  output logic                 illegal,
  output logic [CNT_W-1:0]     retired
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_DCD = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [1:0]       alu_op;

  // Instruction class decode from the latched IR fields
  logic is_addu, is_subu, is_rtype, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal, is_legal;

  assign is_addu  = (opcode == OP_RTYPE) && (funct == FN_ADDU);
  assign is_subu  = (opcode == OP_RTYPE) && (funct == FN_SUBU);
  assign is_rtype = is_addu | is_subu;
  assign is_ori   = (opcode == OP_ORI);
  assign is_lui   = (opcode == OP_LUI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_j     = (opcode == OP_J);
`ifdef MC_JAL_EN
  assign is_jal   = (opcode == OP_JAL);
`else
  // jal is decoded as illegal; with is_jal constant 0 the link output folds to 0
  assign is_jal   = 1'b0;
`endif
  assign is_legal = is_rtype | is_ori | is_lui | is_lw | is_sw |
                    is_beq | is_j | is_jal;

  // Next-state and retire-count logic
  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    case (state_q)
      S_IF:  state_d = mem_ready ? S_DCD : S_IF;
      S_DCD: state_d = is_legal ? S_EXE : S_IF;
      S_EXE: begin
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_beq || is_j || is_jal) begin
          state_d   = S_IF;
          retired_d = retired_q + CNT_W'(1);
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            state_d   = S_IF;
            retired_d = retired_q + CNT_W'(1);
          end
        end
      end
      S_WB: begin
        state_d   = S_IF;
        retired_d = retired_q + CNT_W'(1);
      end
      default: state_d = S_IF;
    endcase
  end

  // State and counter registers; reset returns to fetch from any state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IF;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

  // Moore output decode; everything is forced low while reset is asserted
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    npc_sel    = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    link       = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IF: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_DCD: illegal = ~is_legal;
        S_EXE: begin
          if (is_subu || is_beq) alu_op = 2'b01;
          else if (is_ori)       alu_op = 2'b10;
          else if (is_lui)       alu_op = 2'b11;
          alu_src = is_ori | is_lui | is_lw | is_sw;
          ext_op  = is_lw | is_sw | is_beq;
          if (is_beq) begin
            npc_sel  = 2'b01;
            pc_write = zero;
          end else if (is_j || is_jal) begin
            npc_sel  = 2'b10;
            pc_write = 1'b1;
          end
          reg_write = is_jal;
          link      = is_jal;
        end
        S_MEM: begin
          // Address computation is held so the ALU result stays valid
          iord      = 1'b1;
          alu_src   = 1'b1;
          ext_op    = 1'b1;
          mem_read  = is_lw;
          mem_write = is_sw;
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = is_rtype;
          mem_to_reg = is_lw;
        end
        default: ;
      endcase
    end
  end

  // Widen the 2-bit ALU code; upper bits are always zero
  generate
    if (ALU_CTL_W == 2) begin : g_alu_exact
      assign alu_ctl = alu_op;
    end else begin : g_alu_pad
      assign alu_ctl = {{(ALU_CTL_W-2){1'b0}}, alu_op};
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// Module   : tb_mc_controller
// Purpose  : Self-checking bench for mc_controller using per-cycle directed
//            vectors with hand-computed expected outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_controller;

  logic        clk, rst, zero, mem_ready;
  logic [5:0]  opcode, funct;
  logic        pc_write, ir_write, iord, mem_read, mem_write;
  logic [1:0]  alu_ctl, npc_sel;
  logic        alu_src, ext_op, reg_dst, mem_to_reg, reg_write, link, illegal;
  logic [31:0] retired;

  mc_controller #(.ALU_CTL_W(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .alu_ctl(alu_ctl), .alu_src(alu_src), .ext_op(ext_op),
    .npc_sel(npc_sel), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .link(link), .illegal(illegal), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bit masks for building expected vectors
  localparam logic [15:0] PCW  = 16'h8000, IRW = 16'h4000, IORD = 16'h2000;
  localparam logic [15:0] MRD  = 16'h1000, MWR = 16'h0800;
  localparam logic [15:0] ASUB = 16'h0200, AOR = 16'h0400, ALUI = 16'h0600;
  localparam logic [15:0] ASRC = 16'h0100, EXT = 16'h0080;
  localparam logic [15:0] NBR  = 16'h0020, NJ  = 16'h0040;
  localparam logic [15:0] RDST = 16'h0010, M2R = 16'h0008, RWR = 16'h0004;
  localparam logic [15:0] LNK  = 16'h0002, ILL = 16'h0001;
  localparam logic [15:0] FETCH = MRD | PCW | IRW;

  logic [15:0] act;
  assign act = {pc_write, ir_write, iord, mem_read, mem_write, alu_ctl,
                alu_src, ext_op, npc_sel, reg_dst, mem_to_reg, reg_write,
                link, illegal};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [15:0] exp;
    logic [31:0] ret;
    string       name;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy, input logic [15:0] exp,
                     input logic [31:0] ret, input string name);
    vec_t v;
    v.rst = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
    v.exp = exp; v.ret = ret; v.name = name;
    vq.push_back(v);
  endtask

  task automatic check(input logic [15:0] exp, input logic [31:0] ret,
                       input string name);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s outputs: got %h expected %h", name, act, exp);
    end
    n_tests++;
    if (retired !== ret) begin
      n_fail++;
      $display("FAIL %s retired: got %0d expected %0d", name, retired, ret);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then sample before the rising edge
  task automatic step(input vec_t v);
    @(negedge clk);
    rst = v.rst; opcode = v.op; funct = v.fn; zero = v.z; mem_ready = v.rdy;
    #1;
    check(v.exp, v.ret, v.name);
  endtask

  int jr;

  initial begin
    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
`ifdef MC_JAL_EN
    jr = 1;
`else
    jr = 0;
`endif

    add(1, 6'h00, 6'h21, 0, 1, '0,               0, "reset");
    // addu, mem_ready mostly high, ignored in DCD/EXE/WB
    add(0, 6'h00, 6'h21, 0, 1, FETCH,            0, "addu_if");
    add(0, 6'h00, 6'h21, 0, 0, '0,               0, "addu_dcd");
    add(0, 6'h00, 6'h21, 0, 0, '0,               0, "addu_exe");
    add(0, 6'h00, 6'h21, 0, 0, RWR | RDST,       0, "addu_wb");
    // subu
    add(0, 6'h00, 6'h23, 0, 1, FETCH,            1, "subu_if");
    add(0, 6'h00, 6'h23, 0, 1, '0,               1, "subu_dcd");
    add(0, 6'h00, 6'h23, 0, 1, ASUB,             1, "subu_exe");
    add(0, 6'h00, 6'h23, 0, 1, RWR | RDST,       1, "subu_wb");
    // ori with one fetch wait state
    add(0, 6'h0D, 6'h00, 0, 0, MRD,              2, "ori_ifwait");
    add(0, 6'h0D, 6'h00, 0, 1, FETCH,            2, "ori_if");
    add(0, 6'h0D, 6'h00, 0, 1, '0,               2, "ori_dcd");
    add(0, 6'h0D, 6'h00, 0, 1, AOR | ASRC,       2, "ori_exe");
    add(0, 6'h0D, 6'h00, 0, 1, RWR,              2, "ori_wb");
    // lui
    add(0, 6'h0F, 6'h00, 0, 1, FETCH,            3, "lui_if");
    add(0, 6'h0F, 6'h00, 0, 1, '0,               3, "lui_dcd");
    add(0, 6'h0F, 6'h00, 0, 1, ALUI | ASRC,      3, "lui_exe");
    add(0, 6'h0F, 6'h00, 0, 1, RWR,              3, "lui_wb");
    // lw with 3 memory wait states: 8 cycles total
    add(0, 6'h23, 6'h00, 0, 1, FETCH,            4, "lw_if");
    add(0, 6'h23, 6'h00, 0, 1, '0,               4, "lw_dcd");
    add(0, 6'h23, 6'h00, 0, 1, ASRC | EXT,       4, "lw_exe");
    add(0, 6'h23, 6'h00, 0, 0, IORD | MRD | ASRC | EXT, 4, "lw_mem0");
    add(0, 6'h23, 6'h00, 0, 0, IORD | MRD | ASRC | EXT, 4, "lw_mem1");
    add(0, 6'h23, 6'h00, 0, 0, IORD | MRD | ASRC | EXT, 4, "lw_mem2");
    add(0, 6'h23, 6'h00, 0, 1, IORD | MRD | ASRC | EXT, 4, "lw_mem3");
    add(0, 6'h23, 6'h00, 0, 1, RWR | M2R,        4, "lw_wb");
    // sw
    add(0, 6'h2B, 6'h00, 0, 1, FETCH,            5, "sw_if");
    add(0, 6'h2B, 6'h00, 0, 1, '0,               5, "sw_dcd");
    add(0, 6'h2B, 6'h00, 0, 1, ASRC | EXT,       5, "sw_exe");
    add(0, 6'h2B, 6'h00, 0, 1, IORD | MWR | ASRC | EXT, 5, "sw_mem");
    // beq not taken, then taken
    add(0, 6'h04, 6'h00, 1, 1, FETCH,            6, "beq0_if");
    add(0, 6'h04, 6'h00, 1, 1, '0,               6, "beq0_dcd");
    add(0, 6'h04, 6'h00, 0, 1, ASUB | NBR | EXT, 6, "beq0_exe");
    add(0, 6'h04, 6'h00, 0, 1, FETCH,            7, "beq1_if");
    add(0, 6'h04, 6'h00, 0, 1, '0,               7, "beq1_dcd");
    add(0, 6'h04, 6'h00, 1, 1, ASUB | NBR | EXT | PCW, 7, "beq1_exe");
    // j
    add(0, 6'h02, 6'h00, 0, 1, FETCH,            8, "j_if");
    add(0, 6'h02, 6'h00, 0, 1, '0,               8, "j_dcd");
    add(0, 6'h02, 6'h00, 0, 1, NJ | PCW,         8, "j_exe");
    // illegal opcode 3Fh, then R-type with unsupported funct
    add(0, 6'h3F, 6'h00, 0, 1, FETCH,            9, "ill_if");
    add(0, 6'h3F, 6'h00, 0, 1, ILL,              9, "ill_dcd");
    add(0, 6'h00, 6'h00, 0, 1, FETCH,            9, "illfn_if");
    add(0, 6'h00, 6'h00, 0, 1, ILL,              9, "illfn_dcd");
    // jal: legal only with MC_JAL_EN
    add(0, 6'h03, 6'h00, 0, 1, FETCH,            9, "jal_if");
    add(0, 6'h03, 6'h00, 0, 1, jr ? 16'h0 : ILL, 9, "jal_dcd");
    add(0, 6'h03, 6'h00, 0, 0, jr ? (NJ | PCW | RWR | LNK) : MRD, 9, "jal_nxt");
    add(0, 6'h23, 6'h00, 0, 1, FETCH,            32'(9 + jr), "post_jal_if");

    foreach (vq[i]) step(vq[i]);

    // Reset asserted on the falling edge while lw waits in MEM
    begin
      vec_t v;
      int   r;
      r = 9 + jr;
      v = '{0, 6'h23, 6'h00, 0, 1, 16'h0, r, "rlw_dcd"};           step(v);
      v = '{0, 6'h23, 6'h00, 0, 1, ASRC | EXT, r, "rlw_exe"};      step(v);
      v = '{0, 6'h23, 6'h00, 0, 0, IORD | MRD | ASRC | EXT, r, "rlw_mem"}; step(v);
      v = '{1, 6'h23, 6'h00, 0, 0, 16'h0, 0, "rst_mem"};           step(v);
      v = '{1, 6'h23, 6'h00, 0, 1, 16'h0, 0, "rst_hold"};          step(v);
      v = '{0, 6'h23, 6'h00, 0, 0, MRD, 0, "rst_rel_if"};          step(v);
      v = '{0, 6'h00, 6'h21, 0, 1, FETCH, 0, "rst_rel_fetch"};     step(v);
      v = '{0, 6'h00, 6'h21, 0, 1, 16'h0, 0, "a2_dcd"};            step(v);
      v = '{0, 6'h00, 6'h21, 0, 1, 16'h0, 0, "a2_exe"};            step(v);
      v = '{0, 6'h00, 6'h21, 0, 1, RWR | RDST, 0, "a2_wb"};        step(v);
      v = '{0, 6'h00, 6'h21, 0, 1, FETCH, 1, "a2_done"};           step(v);
    end

    // Reset pulsed mid-cycle, away from any clock edge, while in DCD
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check(16'h0, 0, "async_rst");
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    #1 check(FETCH, 0, "async_rel_if");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
